// File: rtl/prime_pkg.sv
// Shared types and constants for the prime search engine and its divider.
package prime_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DIV   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_OUT   = 3'd5,
        ST_FAIL  = 3'd6
    } prime_state_t;

    // First odd trial divisor and its square.
    localparam int unsigned D_INIT   = 3;
    localparam int unsigned DSQ_INIT = 9;

endpackage

// File: rtl/prime_search_engine_if.sv
// Host-side control and result handshake of the prime search engine.
interface prime_search_engine_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [W-1:0] seed;
    logic         cont;
    logic         busy;
    logic         prime_valid;
    logic [W-1:0] prime;
    logic         prime_ready;
    logic         no_prime;

    modport master (
        output start, seed, cont, prime_ready,
        input  busy, prime_valid, prime, no_prime
    );

    modport slave (
        input  start, seed, cont, prime_ready,
        output busy, prime_valid, prime, no_prime
    );
endinterface

// File: rtl/prime_mod_unit.sv
// Restoring remainder unit: dividend mod divisor, one quotient bit per cycle.
module prime_mod_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] rem
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  sh_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    // Shift one dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [W-1:0] rstep(input logic [W-1:0] r, input logic b,
                                           input logic [W-1:0] dv);
        logic [W:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[W-1:0];
    endfunction

    // The load edge already consumes the first bit, so done follows W cycles after load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (load) begin
            rem_q  <= rstep('0, dividend[W-1], divisor);
            sh_q   <= dividend << 1;
            cnt_q  <= CW'(W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= rstep(rem_q, sh_q[W-1], divisor);
            sh_q   <= sh_q << 1;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign rem  = rem_q;

endmodule

// File: rtl/prime_search_engine.sv
// Searches upward from a seed for the next prime by odd trial division;
// results leave on a valid/ready port, optionally streaming consecutive primes.
module prime_search_engine
    import prime_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter bit          CONT_EN = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    prime_search_engine_if.slave bus
);
    localparam int unsigned DW = 2 * W + 1;
    localparam int unsigned WP = W + 1;

    prime_state_t   state_q, state_n;
    logic [W-1:0]   cand_q, cand_n;
    logic [W-1:0]   d_q, d_n;
    logic [DW-1:0]  dsq_q, dsq_n;
    logic [W-1:0]   prime_q, prime_n;
    logic           valid_q, valid_n;
    logic           busy_q;
    logic           no_prime_q;
    logic           load_c;
    logic           mod_done;
    logic [W-1:0]   mod_rem;
    logic [W:0]     inc1_c;
    logic [W:0]     inc2_c;

    // Carry bit flags a candidate step that leaves the W-bit range.
    assign inc1_c = {1'b0, cand_q} + WP'(1);
    assign inc2_c = {1'b0, cand_q} + WP'(2);

    prime_mod_unit #(.W(W)) u_mod (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .dividend (cand_q),
        .divisor  (d_q),
        .done     (mod_done),
        .rem      (mod_rem)
    );

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        d_n     = d_q;
        dsq_n   = dsq_q;
        prime_n = prime_q;
        valid_n = valid_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cand_n  = bus.seed;
                    state_n = ST_PREP;
                end
            end
            ST_PREP: begin
                if (cand_q < W'(2)) begin
                    cand_n  = W'(2);
                    state_n = ST_OUT;
                end else if (cand_q == W'(2)) begin
                    state_n = ST_OUT;
                end else if (!cand_q[0]) begin
                    if (inc1_c[W]) state_n = ST_FAIL;
                    else           cand_n  = inc1_c[W-1:0];
                end else begin
                    d_n     = W'(D_INIT);
                    dsq_n   = DW'(DSQ_INIT);
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (dsq_q > DW'(cand_q)) begin
                    state_n = ST_OUT;
                end else begin
                    load_c  = 1'b1;
                    state_n = ST_DIV;
                end
            end
            ST_DIV: begin
                if (mod_done) begin
                    if (mod_rem == '0) begin
                        state_n = ST_NEXT;
                    end else begin
                        // (d+2)^2 = d^2 + 4d + 4, kept incrementally to avoid a multiplier.
                        dsq_n   = dsq_q + (DW'(d_q) << 2) + DW'(4);
                        d_n     = d_q + W'(2);
                        state_n = ST_CHECK;
                    end
                end
            end
            ST_NEXT: begin
                if (inc2_c[W]) begin
                    state_n = ST_FAIL;
                end else begin
                    cand_n  = inc2_c[W-1:0];
                    d_n     = W'(D_INIT);
                    dsq_n   = DW'(DSQ_INIT);
                    state_n = ST_CHECK;
                end
            end
            ST_OUT: begin
                if (!valid_q) begin
                    valid_n = 1'b1;
                    prime_n = cand_q;
                end else if (bus.prime_ready) begin
                    valid_n = 1'b0;
                    if (CONT_EN && bus.cont) begin
                        if (inc1_c[W]) begin
                            state_n = ST_FAIL;
                        end else begin
                            cand_n  = inc1_c[W-1:0];
                            state_n = ST_PREP;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            d_q        <= '0;
            dsq_q      <= '0;
            prime_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            no_prime_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cand_q     <= cand_n;
            d_q        <= d_n;
            dsq_q      <= dsq_n;
            prime_q    <= prime_n;
            valid_q    <= valid_n;
            busy_q     <= (state_n != ST_IDLE);
            no_prime_q <= (state_n == ST_FAIL);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.prime_valid = valid_q;
    assign bus.prime       = prime_q;
    assign bus.no_prime    = no_prime_q;

endmodule

// File: tb/tb_prime_search_engine.sv
// Self-checking bench: W=16 directed runs and W=12 seeds against a next-prime model.
module tb_prime_search_engine;

    logic clk;
    logic rst;

    prime_search_engine_if #(.W(16)) if16();
    prime_search_engine_if #(.W(12)) if12();

    prime_search_engine #(.W(16), .CONT_EN(1'b1)) u16 (.clk(clk), .rst(rst), .bus(if16));
    prime_search_engine #(.W(12), .CONT_EN(1'b1)) u12 (.clk(clk), .rst(rst), .bus(if12));

    int nchk = 0;
    int nfail = 0;
    int m_exp [2];
    int acc   [2];
    int np_cnt[2];
    int vseen [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        nchk++;
        if (act != want) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit is_prime(input int c);
        if (c < 2) return 1'b0;
        for (int k = 2; k * k <= c; k++) if (c % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int s, input int w);
        for (int c = (s < 2) ? 2 : s; c < (1 << w); c++) if (is_prime(c)) return c;
        return -1;
    endfunction

    function automatic int valid_of(input int sel);
        return (sel == 0) ? int'(if16.prime_valid) : int'(if12.prime_valid);
    endfunction
    function automatic int prime_of(input int sel);
        return (sel == 0) ? int'(if16.prime) : int'(if12.prime);
    endfunction
    function automatic int busy_of(input int sel);
        return (sel == 0) ? int'(if16.busy) : int'(if12.busy);
    endfunction
    function automatic int np_of(input int sel);
        return (sel == 0) ? int'(if16.no_prime) : int'(if12.no_prime);
    endfunction

    // Per-cycle compare of a port against the model expectation.
    task automatic mon(input int sel, input logic v, input logic r, input logic c,
                       input logic np, input int pr, input int w);
        if (v) begin
            vseen[sel]++;
            chk($sformatf("mon_prime%0d", sel), pr, m_exp[sel]);
            if (r) begin
                acc[sel]++;
                if (c) m_exp[sel] = next_prime(pr + 1, w);
            end
        end
        if (np) begin
            np_cnt[sel]++;
            chk($sformatf("mon_noprime%0d", sel), m_exp[sel], -1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if16.prime_valid, if16.prime_ready, if16.cont, if16.no_prime, int'(if16.prime), 16);
            mon(1, if12.prime_valid, if12.prime_ready, if12.cont, if12.no_prime, int'(if12.prime), 12);
        end
    end

    task automatic start_search(input int sel, input int s);
        @(posedge clk); #1;
        if (sel == 0) begin if16.seed = 16'(s); if16.start = 1'b1; end
        else          begin if12.seed = 12'(s); if12.start = 1'b1; end
        m_exp[sel] = next_prime(s, (sel == 0) ? 16 : 12);
        @(posedge clk); #1;
        if16.start = 1'b0;
        if12.start = 1'b0;
    endtask

    // res: prime value, -1 for no_prime, -2 on timeout. cyc counts edges after the start edge.
    task automatic wait_result(input int sel, input int maxcyc, output int cyc, output int res);
        res = -2;
        cyc = 0;
        while (res == -2 && cyc < maxcyc) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_of(sel) != 0)   res = prime_of(sel);
            else if (np_of(sel) != 0) res = -1;
        end
        if (res == -2) begin
            nchk++;
            nfail++;
            $display("FAIL timeout sel=%0d: got no result expected one within %0d cycles", sel, maxcyc);
        end
    endtask

    int seeds16[7] = '{0, 1, 2, 3, 14, 97, 65521};
    int exps16 [7] = '{2, 2, 2, 3, 17, 97, 65521};
    int lat16  [7] = '{2, 2, 2, 3, 0, 0, 0};
    int stream [5] = '{11, 13, 17, 19, 23};
    int fixed12[7] = '{4093, 4094, 4095, 0, 1, 3, 4092};

    initial begin
        int cyc, res, a0, n0, v0, s, want;
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = -3; acc[i] = 0; np_cnt[i] = 0; vseen[i] = 0;
        end
        rst = 1'b1;
        if16.start = 1'b0; if16.seed = '0; if16.cont = 1'b0; if16.prime_ready = 1'b1;
        if12.start = 1'b0; if12.seed = '0; if12.cont = 1'b0; if12.prime_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int sel = 0; sel < 2; sel++) begin
            chk("rst_busy", busy_of(sel), 0);
            chk("rst_valid", valid_of(sel), 0);
            chk("rst_prime", prime_of(sel), 0);
            chk("rst_noprime", np_of(sel), 0);
        end
        rst = 1'b0;

        // Single searches, W=16.
        for (int i = 0; i < 7; i++) begin
            a0 = acc[0]; n0 = np_cnt[0];
            start_search(0, seeds16[i]);
            wait_result(0, 20000, cyc, res);
            chk($sformatf("prime_seed%0d", seeds16[i]), res, exps16[i]);
            if (lat16[i] != 0) chk($sformatf("latency_seed%0d", seeds16[i]), cyc, lat16[i]);
            @(posedge clk); #1;
            chk("busy_after_accept", busy_of(0), 0);
            chk("accept_count", acc[0] - a0, 1);
            chk("noprime_quiet", np_cnt[0] - n0, 0);
        end

        // No prime above the seed.
        a0 = acc[0]; n0 = np_cnt[0]; v0 = vseen[0];
        start_search(0, 65522);
        wait_result(0, 20000, cyc, res);
        chk("noprime_65522", res, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("noprime_pulse_once", np_cnt[0] - n0, 1);
        chk("noprime_no_valid", vseen[0] - v0, 0);
        chk("noprime_idle", busy_of(0), 0);

        // Continuous stream from 10.
        if16.cont = 1'b1;
        start_search(0, 10);
        for (int i = 0; i < 5; i++) begin
            wait_result(0, 5000, cyc, res);
            chk($sformatf("stream%0d", i), res, stream[i]);
            if (i == 4) if16.cont = 1'b0;
            @(posedge clk); #1;
            chk("stream_gap", valid_of(0), 0);
        end
        chk("stream_idle", busy_of(0), 0);

        // Backpressure with a stray start while busy.
        if16.prime_ready = 1'b0;
        start_search(0, 14);
        wait_result(0, 5000, cyc, res);
        chk("bp_first", res, 17);
        a0 = acc[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin if16.start = 1'b1; if16.seed = 16'd3; end
            else if16.start = 1'b0;
            chk("bp_hold_prime", prime_of(0), 17);
            chk("bp_hold_valid", valid_of(0), 1);
            chk("bp_hold_busy", busy_of(0), 1);
        end
        if16.start = 1'b0;
        if16.prime_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept_valid", valid_of(0), 0);
        chk("bp_accept_busy", busy_of(0), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accept_once", acc[0] - a0, 1);
        chk("bp_start_ignored", busy_of(0), 0);

        // Reset in the middle of a long search, with start held during reset.
        start_search(0, 65521);
        repeat (40) @(posedge clk);
        #1;
        chk("midsearch_busy", busy_of(0), 1);
        rst = 1'b1;
        if16.start = 1'b1;
        if16.seed = 16'd99;
        @(posedge clk); #1;
        chk("midrst_busy", busy_of(0), 0);
        chk("midrst_valid", valid_of(0), 0);
        chk("midrst_prime", prime_of(0), 0);
        chk("midrst_noprime", np_of(0), 0);
        rst = 1'b0;
        if16.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_with_rst_ignored", busy_of(0), 0);
        start_search(0, 20);
        wait_result(0, 5000, cyc, res);
        chk("after_rst_seed20", res, 23);
        @(posedge clk); #1;
        chk("after_rst_idle", busy_of(0), 0);

        // W=12 seeds against the model.
        for (int i = 0; i < 32; i++) begin
            s = (i < 7) ? fixed12[i] : int'($urandom_range(0, 4095));
            want = next_prime(s, 12);
            start_search(1, s);
            wait_result(1, 20000, cyc, res);
            chk($sformatf("w12_seed%0d", s), res, want);
            @(posedge clk); #1;
            chk("w12_idle", busy_of(1), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected end of test before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
